elevator_controller: RTL

Floor-scheduling controller for the 4-stage elevator. Consumes the hall-call pair produced by the call-button decoder (`up_or_down[1:0]` plus the 2-bit stage of the call), latches calls into pending-call registers, and drives car movement one stage at a time. It schedules with a SCAN (collective) policy, opens the door on arrival, and exports car position and status to the display and motor stages.

---
 rtl/elevator_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/elevator_controller.sv
// elevator_controller
//   SCAN (collective) floor scheduler for a 4-stage car. Hall calls from the
//   button decoder are latched into per-stage up/down call registers. The car
//   moves one stage per MOVE_CYCLES, stops where the SCAN rules say so, and
//   holds the door open for DOOR_CYCLES (re-armed by a call at the car's stage).
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   up_or_down     [0] call valid, [1] 1=up / 0=down
//   call_stage     stage of the call (valid with up_or_down[0])
//   current_stage  car position 0..3
//   moving_up      car moving, direction up
//   moving_down    car moving, direction down
//   door_open      door held open
//   pending        per-stage OR of up and down calls
//   dbg_state_o    controller state (0 idle, 1 move, 2 door)
//
// Handshake: calls are level-sampled on every rising edge while
// up_or_down[0]=1; there is no ready/acknowledge, repeated sampling of the
// same call is harmless because setting a set bit changes nothing.
module elevator_controller #(
    parameter int unsigned MOVE_CYCLES = 50_000_000,
    parameter int unsigned DOOR_CYCLES = 100_000_000,
    parameter int unsigned TW          = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] up_or_down,
    input  logic [1:0] call_stage,
    output logic [1:0] current_stage,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_e;

    localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    stage_q, stage_d;
    logic          dir_q, dir_d;          // 1 = up
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    up_q, up_d, dn_q, dn_d;
    logic [3:0]    up_set, dn_set, up_clr, dn_clr;
    logic [3:0]    calls;
    logic          reopen;
    logic [1:0]    next_stage;
    logic          ahead_n, dir_hit;
    logic          moving_up_q, moving_down_q, door_open_q;
    logic [3:0]    pending_q;

    function automatic logic any_above(input logic [3:0] c, input logic [1:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(s) && c[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [3:0] c, input logic [1:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(s) && c[i]) r = 1'b1;
        end
        return r;
    endfunction

    assign calls = up_q | dn_q;

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        up_set     = '0;
        dn_set     = '0;
        up_clr     = '0;
        dn_clr     = '0;
        next_stage = stage_q;
        ahead_n    = 1'b0;
        dir_hit    = 1'b0;

        // A call for the stage whose door is open re-arms the door instead
        // of being stored.
        reopen = up_or_down[0] && (state_q == S_DOOR) && (call_stage == stage_q);

        // An up call at the top and a down call at the bottom can only be
        // served from the other direction, so they are stored there.
        if (up_or_down[0] && !reopen) begin
            if ((up_or_down[1] && call_stage != 2'd3) || call_stage == 2'd0) begin
                up_set[call_stage] = 1'b1;
            end else begin
                dn_set[call_stage] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (calls[stage_q]) begin
                    state_d         = S_DOOR;
                    timer_d         = DOOR_LOAD;
                    up_clr[stage_q] = 1'b1;
                    dn_clr[stage_q] = 1'b1;
                end else if (any_above(calls, stage_q) && any_below(calls, stage_q)) begin
                    state_d = S_MOVE;
                    timer_d = MOVE_LOAD;
                end else if (any_above(calls, stage_q)) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b1;
                    timer_d = MOVE_LOAD;
                end else if (any_below(calls, stage_q)) begin
                    state_d = S_MOVE;
                    dir_d   = 1'b0;
                    timer_d = MOVE_LOAD;
                end
            end
            S_MOVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    next_stage = dir_q ? stage_q + 2'd1 : stage_q - 2'd1;
                    stage_d    = next_stage;
                    ahead_n    = dir_q ? any_above(calls, next_stage)
                                       : any_below(calls, next_stage);
                    dir_hit    = dir_q ? up_q[next_stage] : dn_q[next_stage];
                    if (dir_hit || (!ahead_n && calls[next_stage])) begin
                        state_d = S_DOOR;
                        timer_d = DOOR_LOAD;
                        if (dir_q) up_clr[next_stage] = 1'b1;
                        else       dn_clr[next_stage] = 1'b1;
                        // End of the sweep: serve both directions here and turn.
                        if (!ahead_n) begin
                            up_clr[next_stage] = 1'b1;
                            dn_clr[next_stage] = 1'b1;
                            dir_d              = ~dir_q;
                        end
                    end else begin
                        timer_d = MOVE_LOAD;
                    end
                end
            end
            S_DOOR: begin
                if (reopen) begin
                    timer_d = DOOR_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear wins over a same-edge set of the same bit.
        up_d = (up_q | up_set) & ~up_clr;
        dn_d = (dn_q | dn_set) & ~dn_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            stage_q       <= 2'd0;
            dir_q         <= 1'b1;
            timer_q       <= '0;
            up_q          <= '0;
            dn_q          <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
            pending_q     <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            dir_q         <= dir_d;
            timer_q       <= timer_d;
            up_q          <= up_d;
            dn_q          <= dn_d;
            moving_up_q   <= (state_d == S_MOVE) && dir_d;
            moving_down_q <= (state_d == S_MOVE) && !dir_d;
            door_open_q   <= (state_d == S_DOOR);
            pending_q     <= up_d | dn_d;
        end
    end

    assign current_stage = stage_q;
    assign moving_up     = moving_up_q;
    assign moving_down   = moving_down_q;
    assign door_open     = door_open_q;
    assign pending       = pending_q;
    assign dbg_state_o   = state_q;

endmodule
